// File: rtl/yarvi_dmem_arb_if.sv
// Bus bundle between the core/debug requesters, the data-memory arbiter and the memory.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface yarvi_dmem_arb_if #(
  parameter int AW = 32
);
  logic          c_req, c_we, c_ready, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [31:0]   c_wdata, c_rdata;
  logic [3:0]    c_mask;

  logic          d_req, d_we, d_ready, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata, d_rdata;
  logic [3:0]    d_mask;

  logic          m_valid, m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata, m_rdata;
  logic [3:0]    m_mask;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_mask,
    output c_ready, c_rvalid, c_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_mask,
    output d_ready, d_rvalid, d_rdata,
    output m_valid, m_we, m_addr, m_wdata, m_mask,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_mask,
    input  c_ready, c_rvalid, c_rdata,
    output d_req, d_we, d_addr, d_wdata, d_mask,
    input  d_ready, d_rvalid, d_rdata,
    input  m_valid, m_we, m_addr, m_wdata, m_mask,
    output m_rdata
  );
endinterface

// File: rtl/yarvi_dmem_arb.sv
// Two-requester data-memory arbiter: core wins by default, debug wins after
// STARVE_LIMIT consecutive denials. Read data is routed back one cycle after grant.
module yarvi_dmem_arb #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  yarvi_dmem_arb_if.slave   bus
);
  localparam int WW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [WW-1:0] LIM = WW'(STARVE_LIMIT);

  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_owner_q, rd_owner_d;  // 1 = debug owns the outstanding read

  logic          starve, c_gnt, d_gnt, rd_gnt, we_sel;
  logic [AW-1:0] addr_sel;
  logic [31:0]   wdata_sel;
  logic [3:0]    mask_sel;

  always_comb begin
    // With STARVE_LIMIT=0 the counter sits at LIM permanently, so debug always wins.
    starve = (wcnt_q == LIM);
    d_gnt  = reset_n & bus.d_req & (~bus.c_req | starve);
    c_gnt  = reset_n & bus.c_req & ~d_gnt;

    we_sel    = d_gnt ? bus.d_we    : bus.c_we;
    addr_sel  = d_gnt ? bus.d_addr  : bus.c_addr;
    wdata_sel = d_gnt ? bus.d_wdata : bus.c_wdata;
    mask_sel  = d_gnt ? bus.d_mask  : bus.c_mask;

    bus.c_ready = c_gnt;
    bus.d_ready = d_gnt;
    bus.m_valid = c_gnt | d_gnt;
    bus.m_we    = bus.m_valid & we_sel;
    bus.m_addr  = addr_sel;
    bus.m_wdata = wdata_sel;
    bus.m_mask  = bus.m_we ? mask_sel : 4'h0;

    rd_gnt     = bus.m_valid & ~we_sel;
    rd_pend_d  = rd_gnt;
    rd_owner_d = rd_gnt ? d_gnt : rd_owner_q;

    wcnt_d = wcnt_q;
    if (!bus.d_req || d_gnt) wcnt_d = '0;
    else if (wcnt_q != LIM)  wcnt_d = wcnt_q + 1'b1;

    bus.c_rvalid = rd_pend_q & ~rd_owner_q;
    bus.d_rvalid = rd_pend_q &  rd_owner_q;
    bus.c_rdata  = bus.c_rvalid ? bus.m_rdata : 32'h0;
    bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : 32'h0;
  end

  // Async reset also drops a read granted just before reset, so no stale rvalid appears.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wcnt_q     <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      wcnt_q     <= wcnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end
endmodule

// File: tb/tb_yarvi_dmem_arb.sv
// Scoreboard bench for yarvi_dmem_arb: grant/forwarding checked each cycle,
// expected read responses queued at grant and compared one cycle later.
module tb_yarvi_dmem_arb;
  localparam int LIMIT = 4;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  yarvi_dmem_arb_if #(.AW(32)) bus ();

  yarvi_dmem_arb #(.STARVE_LIMIT(LIMIT), .AW(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic        c;
    logic        d;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   wcnt   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // One arbitration cycle: drive at negedge, check #1 later, update the model.
  task automatic step(input logic cr, input logic cwe, input logic [31:0] ca, input logic [31:0] cwd,
                      input logic [3:0] cm, input logic dr, input logic dwe, input logic [31:0] da,
                      input logic [31:0] dwd, input logic [3:0] dm, output logic gc, output logic gd);
    rsp_t e;
    logic st, ec, ed, ewe;
    logic [31:0] ea, ewd;
    logic [3:0] emk;
    @(negedge clock);
    bus.c_req = cr; bus.c_we = cwe; bus.c_addr = ca; bus.c_wdata = cwd; bus.c_mask = cm;
    bus.d_req = dr; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd; bus.d_mask = dm;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      e = '{1'b0, 1'b0, 32'h0};
    end else e = sb.pop_front();
    bus.m_rdata = e.data;
    #1;
    chk("c_rvalid", bus.c_rvalid, e.c);
    chk("d_rvalid", bus.d_rvalid, e.d);
    chk("c_rdata", bus.c_rdata, e.c ? e.data : 32'h0);
    chk("d_rdata", bus.d_rdata, e.d ? e.data : 32'h0);
    st  = (wcnt == LIMIT);
    ed  = dr & (~cr | st);
    ec  = cr & ~ed;
    ewe = ed ? dwe : (ec ? cwe : 1'b0);
    ea  = ed ? da : ca;
    ewd = ed ? dwd : cwd;
    emk = ewe ? (ed ? dm : cm) : 4'h0;
    chk("c_ready", bus.c_ready, ec);
    chk("d_ready", bus.d_ready, ed);
    chk("m_valid", bus.m_valid, ec | ed);
    chk("m_we", bus.m_we, ewe);
    chk("m_mask", bus.m_mask, emk);
    if (ec | ed) begin
      chk("m_addr", bus.m_addr, ea);
      chk("m_wdata", bus.m_wdata, ewd);
    end
    wcnt = (!dr || ed) ? 0 : ((wcnt < LIMIT) ? wcnt + 1 : wcnt);
    sb.push_back('{ec & ~cwe, ed & ~dwe, $urandom});
    gc = ec;
    gd = ed;
  endtask

  task automatic rd2(input logic cr, input logic [31:0] ca, input logic dr, input logic [31:0] da,
                     output logic gc, output logic gd);
    step(cr, 1'b0, ca, 32'h0, 4'hF, dr, 1'b0, da, 32'h0, 4'hF, gc, gd);
  endtask

  task automatic idle();
    logic gc, gd;
    rd2(1'b0, 32'h0, 1'b0, 32'h0, gc, gd);
  endtask

  initial begin
    logic gc, gd;
    int ncore;
    reset_n = 1'b0;
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0; bus.c_mask = '0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_mask = '0;
    bus.m_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rst_c_ready", bus.c_ready, 0);
    chk("rst_d_ready", bus.d_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_rvalid", {bus.c_rvalid, bus.d_rvalid}, 0);
    chk("rst_rdata", {bus.c_rdata, bus.d_rdata}, 0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    sb.push_back('{1'b0, 1'b0, 32'h0});

    // single core read, then its response
    rd2(1'b1, 32'h8000_0010, 1'b0, 32'h0, gc, gd);
    chk("core_rd_gnt", gc, 1);
    idle();

    // debug write: no response follows
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h8000_0100, 32'hCAFE_F00D, 4'hF, gc, gd);
    chk("dbg_wr_gnt", gd, 1);
    idle();

    // both held: debug wins every 5th cycle
    for (int i = 0; i < 10; i++) begin
      rd2(1'b1, 32'h1000 + 32'(i * 4), 1'b1, 32'h2000 + 32'(i * 4), gc, gd);
      chk("starve_pattern", gd, (i == 4 || i == 9));
    end
    idle();

    // alternating core/debug reads back-to-back
    for (int i = 0; i < 6; i++)
      rd2(i[0] == 1'b0, 32'h3000 + 32'(i), i[0] == 1'b1, 32'h4000 + 32'(i), gc, gd);
    idle();

    // debug waits 2 cycles, withdraws, then must wait the full limit again
    rd2(1'b1, 32'h5000, 1'b1, 32'h6000, gc, gd);
    rd2(1'b1, 32'h5004, 1'b1, 32'h6004, gc, gd);
    rd2(1'b1, 32'h5008, 1'b0, 32'h6008, gc, gd);
    ncore = 0;
    gd = 1'b0;
    for (int i = 0; i < 10 && !gd; i++) begin
      rd2(1'b1, 32'h5100, 1'b1, 32'h6100, gc, gd);
      if (gc) ncore++;
    end
    chk("rewait_gd", gd, 1);
    chk("rewait_cnt", ncore, LIMIT);
    idle();

    // async reset right after a debug read grant
    rd2(1'b0, 32'h0, 1'b1, 32'h7000, gc, gd);
    chk("pre_rst_dgnt", gd, 1);
    bus.c_req = 1'b1;
    @(posedge clock);
    #2 reset_n = 1'b0;
    bus.m_rdata = 32'h5555_AAAA;
    #1;
    chk("midrst_d_rvalid", bus.d_rvalid, 0);
    chk("midrst_d_rdata", bus.d_rdata, 0);
    chk("midrst_c_ready", bus.c_ready, 0);
    chk("midrst_m_valid", bus.m_valid, 0);
    chk("midrst_state", {dut.wcnt_q, dut.rd_pend_q, dut.rd_owner_q}, 0);
    @(posedge clock);
    #1;
    chk("inrst_d_rvalid", bus.d_rvalid, 0);
    #2 reset_n = 1'b1;
    wcnt = 0;
    sb.delete();
    sb.push_back('{1'b0, 1'b0, 32'h0});
    rd2(1'b1, 32'h8000_0020, 1'b0, 32'h0, gc, gd);
    chk("post_rst_cgnt", gc, 1);
    idle();

    // random traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom),
           gc, gd);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
